instruction_fetch_responder: RTL

INSTRUCTION_FETCH_RESPONDER -- requirements
Module: instruction_fetch_responder

---
 rtl/instruction_fetch_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/instruction_fetch_responder.sv
// instruction_fetch_responder: one-entry instruction buffer that fills itself from backing memory on a miss
module instruction_fetch_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instruction_addr,
  input  logic                  instruction_fetch_activate,
  output logic [DATA_WIDTH-1:0] instruction_data,
  output logic                  instruction_fetch_done,
  output logic                  instruction_fetch_fault,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic entry_valid_q, entry_valid_d, entry_fault_q, entry_fault_d, stale_q, stale_d, hit, fill;
  logic [ADDR_WIDTH-1:0] entry_tag_q, entry_tag_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] entry_data_q, entry_data_d;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    hit           = entry_valid_q && instruction_fetch_activate && (instruction_addr == entry_tag_q);
    state_d       = state_q;
    entry_valid_d = entry_valid_q;
    entry_tag_d   = entry_tag_q;
    entry_data_d  = entry_data_q;
    entry_fault_d = entry_fault_q;
    stale_d       = stale_q;
    mem_addr_d    = mem_addr_q;
    cnt_d         = cnt_q;
    fill          = 1'b0;
    if (state_q == IDLE) begin
      if (instruction_fetch_activate && !hit && !flush) begin
        if (instruction_addr[1:0] == 2'b00) begin
          mem_addr_d = instruction_addr;
          cnt_d      = '0;
          stale_d    = 1'b0;
          state_d    = REQ;
        end else begin
          entry_valid_d = 1'b1;
          entry_tag_d   = instruction_addr;
          entry_data_d  = '0;
          entry_fault_d = 1'b1;
        end
      end
    end else begin
      fill    = mem_ack || (cnt_q == LAST);
      cnt_d   = fill ? cnt_q : cnt_q + 16'd1;
      state_d = fill ? IDLE : REQ;
      // a read flushed while in flight completes on the bus but never becomes valid
      if (fill && !stale_q) begin
        entry_valid_d = 1'b1;
        entry_tag_d   = mem_addr_q;
        entry_data_d  = (mem_ack && !mem_err) ? mem_rdata : '0;
        entry_fault_d = !mem_ack || mem_err;
      end
    end
    if (flush) begin
      entry_valid_d = 1'b0;
      stale_d       = (state_q == REQ) ? 1'b1 : stale_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      entry_valid_q <= 1'b0;
      entry_tag_q   <= '0;
      entry_data_q  <= '0;
      entry_fault_q <= 1'b0;
      stale_q       <= 1'b0;
      mem_addr_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      entry_valid_q <= entry_valid_d;
      entry_tag_q   <= entry_tag_d;
      entry_data_q  <= entry_data_d;
      entry_fault_q <= entry_fault_d;
      stale_q       <= stale_d;
      mem_addr_q    <= mem_addr_d;
      cnt_q         <= cnt_d;
    end
  end
  assign instruction_data        = entry_data_q;
  assign instruction_fetch_done  = hit && !rst;
  assign instruction_fetch_fault = hit && entry_fault_q && !rst;
  assign mem_req                 = (state_q == REQ) && !rst;
  assign mem_addr                = mem_addr_q;
endmodule
